// File: rtl/bit_diff_sched_pkg.sv
// Shared types and helpers for the bit_diff request scheduler.
package bit_diff_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } sched_state_t;

    function automatic int result_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/bit_diff_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bit_diff_scheduler.sv
// Shares one bit_diff engine among NUM_REQ requesters, round-robin,
// with a credit counter guarding the downstream result FIFO.
module bit_diff_scheduler
    import bit_diff_sched_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int WIDTH        = 32,
    parameter  int RESULT_WIDTH = result_width(WIDTH),
    parameter  int CREDITS      = 16,
    localparam int IDW          = $clog2(NUM_REQ),
    localparam int CW           = $clog2(CREDITS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            eng_go,
    output logic [WIDTH-1:0]                eng_data,
    input  logic                            eng_done,
    input  logic [RESULT_WIDTH-1:0]         eng_result,
    output logic                            out_valid,
    output logic [RESULT_WIDTH-1:0]         out_data,
    output logic [IDW-1:0]                  out_id,
    input  logic                            credit_return,
    output logic                            busy
);

    sched_state_t            state_q;
    logic [IDW-1:0]          rr_ptr_q;
    logic [CW-1:0]           credit_q;
    logic [CW-1:0]           credit_d;
    logic                    eng_done_q;
    logic                    eng_go_q;
    logic [WIDTH-1:0]        eng_data_q;
    logic                    out_valid_q;
    logic [RESULT_WIDTH-1:0] out_data_q;
    logic [IDW-1:0]          out_id_q;

    logic                    arb_en;
    logic [NUM_REQ-1:0]      gnt;
    logic [IDW-1:0]          gnt_idx;
    logic                    grant;
    logic [IDW-1:0]          next_ptr;

    // Reset masks req_ready so no handshake is seen while the block is held.
    assign arb_en = !rst && (state_q == IDLE) && (credit_q != '0);

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (grant)
    );

    assign next_ptr = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_comb begin
        credit_d = credit_q;
        if (grant && !credit_return) begin
            credit_d = credit_q - CW'(1);
        end else if (!grant && credit_return && credit_q != CW'(CREDITS)) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            credit_q    <= CW'(CREDITS);
            eng_done_q  <= 1'b0;
            eng_go_q    <= 1'b0;
            eng_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            eng_done_q  <= eng_done;
            credit_q    <= credit_d;
            eng_go_q    <= 1'b0;
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        eng_data_q <= req_data[gnt_idx];
                        out_id_q   <= gnt_idx;
                        rr_ptr_q   <= next_ptr;
                        eng_go_q   <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                // A done level left over from the last job falls before it can
                // rise again, so only a fresh edge captures.
                WAIT: begin
                    if (eng_done && !eng_done_q) begin
                        out_data_q  <= eng_result;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = gnt;
    assign eng_go    = eng_go_q;
    assign eng_data  = eng_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bit_diff_scheduler.sv
// Scoreboard bench for bit_diff_scheduler with a behavioural engine and
// a cycle-level reference of grant order, credits and latency.
module tb_bit_diff_scheduler;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int RW = 7;
    localparam int CR = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0][W-1:0] req_data = '0;
    logic [NR-1:0]        req_ready;
    logic                 eng_go;
    logic [W-1:0]         eng_data;
    logic                 eng_done;
    logic [RW-1:0]        eng_result;
    logic                 out_valid;
    logic [RW-1:0]        out_data;
    logic [1:0]           out_id;
    logic                 credit_return = 1'b0;
    logic                 busy;

    always #5 clk = ~clk;

    bit_diff_scheduler #(
        .NUM_REQ (NR),
        .WIDTH   (W),
        .CREDITS (CR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .eng_go        (eng_go),
        .eng_data      (eng_data),
        .eng_done      (eng_done),
        .eng_result    (eng_result),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id),
        .credit_return (credit_return),
        .busy          (busy)
    );

    // Engine: done rises 33 cycles after go and stays high until the next go.
    logic [RW-1:0] eng_res_q;
    logic [RW-1:0] junk_q;
    int            eng_cnt;

    function automatic logic [RW-1:0] engine_fn(input logic [W-1:0] d);
        int ones;
        ones = 0;
        for (int b = 0; b < W; b++) if (d[b]) ones++;
        return RW'(ones - (W - ones));
    endfunction

    always @(posedge clk) begin
        junk_q <= RW'($urandom);
        if (rst) begin
            eng_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (eng_go) begin
            eng_done  <= 1'b0;
            eng_cnt   <= 32;
            eng_res_q <= engine_fn(eng_data);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_done <= 1'b1;
        end
    end

    assign eng_result = eng_done ? eng_res_q : junk_q;

    typedef struct {
        int            id;
        logic [RW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            ret_q[$];
    int            gnt_order[$];
    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    int            m_ptr, m_cred, m_free_at, go_cyc, out_cyc, last_grant;
    int            mode, auto_ret, rand_ret, ret_at, hs_cnt, last_id;
    logic [W-1:0]  flip;
    logic [RW-1:0] last_data;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      name, act, exp, cyc);
    endtask

    function automatic logic [RW-1:0] ref_res(input logic [W-1:0] d);
        return RW'(2 * $countones(d) - W);
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: id %0d data %0h at cycle %0d",
                         out_id, out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_id", 64'(out_id), 64'(e.id));
                chk("out_latency", 64'(cyc - e.cyc), 64'(35));
                last_data = out_data;
                last_id   = int'(out_id);
            end
        end
    end

    task automatic step();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] xfer;
        logic          grant;
        int            g;
        int            idx;
        @(negedge clk);
        exp_rdy = '0;
        grant   = 1'b0;
        g       = 0;
        if (cyc >= m_free_at && m_cred > 0) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (!grant && req_valid[idx]) begin
                    grant        = 1'b1;
                    g            = idx;
                    exp_rdy[idx] = 1'b1;
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("eng_go", 64'(eng_go), 64'(cyc == go_cyc));
        chk("out_valid", 64'(out_valid), 64'(cyc == out_cyc));
        chk("busy", 64'(busy), 64'(cyc < m_free_at));
        if (grant) begin
            exp_q.push_back('{g, ref_res(req_data[g]), cyc});
            m_ptr      = (g + 1) % NR;
            m_free_at  = cyc + 36;
            go_cyc     = cyc + 1;
            out_cyc    = cyc + 35;
            last_grant = cyc;
        end
        if (grant && !credit_return) m_cred--;
        else if (!grant && credit_return && m_cred < CR) m_cred++;
        xfer = req_valid & req_ready;
        for (int i = 0; i < NR; i++) begin
            if (xfer[i]) begin
                hs_cnt++;
                gnt_order.push_back(i);
            end
        end
        if (out_valid && auto_ret != 0)
            ret_q.push_back(cyc + 1 + int'($urandom_range(0, 4)));
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (xfer[i]) begin
                if (mode == 1) req_data[i] = req_data[i] ^ flip;
                else req_valid[i] = 1'b0;
            end else if (mode == 2 && !req_valid[i] &&
                         $urandom_range(0, 3) == 0) begin
                req_valid[i] = 1'b1;
                req_data[i]  = rand_word();
            end
        end
        credit_return = (cyc == ret_at);
        if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            void'(ret_q.pop_front());
            credit_return = 1'b1;
        end
        if (rand_ret != 0 && $urandom_range(0, 15) == 0) credit_return = 1'b1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        credit_return = 1'b0;
        req_valid     = '0;
        mode          = 0;
        auto_ret      = 0;
        rand_ret      = 0;
        @(posedge clk);
        cyc++;
        #1;
        @(negedge clk);
        chk("reset_outputs",
            64'({eng_go, eng_data, out_valid, out_data, out_id, busy, req_ready}),
            64'(0));
        @(posedge clk);
        cyc++;
        #1;
        rst       = 1'b0;
        m_ptr     = 0;
        m_cred    = CR;
        m_free_at = 0;
        go_cyc    = -100;
        out_cyc   = -100;
        ret_at    = -100;
        hs_cnt    = 0;
        last_id   = -1;
        last_data = '0;
        exp_q.delete();
        ret_q.delete();
        gnt_order.delete();
    endtask

    initial begin
        flip = '0;
        @(posedge clk);
        #1;

        // Single requester, all ones.
        do_reset();
        req_data[2]  = 32'hFFFF_FFFF;
        req_valid[2] = 1'b1;
        repeat (40) step();
        chk("p1_handshakes", 64'(hs_cnt), 64'(1));
        chk("p1_id", 64'(last_id), 64'(2));
        chk("p1_data", 64'(last_data), 64'(7'h20));

        // Four continuous requesters, zero data.
        do_reset();
        mode      = 1;
        flip      = '0;
        auto_ret  = 1;
        req_data  = '0;
        req_valid = '1;
        repeat (5 * 36 + 5) step();
        chk("p2_grants", 64'(gnt_order.size()), 64'(6));
        for (int k = 0; k < 5 && k < gnt_order.size(); k++)
            chk("p2_order", 64'(gnt_order[k]), 64'(k % 4));
        chk("p2_data", 64'(last_data), 64'(7'h60));

        // Credit exhaustion then one returned credit.
        do_reset();
        mode = 1;
        flip = $urandom;
        for (int i = 0; i < NR; i++) req_data[i] = rand_word();
        req_valid = '1;
        repeat (150) step();
        chk("p3_exhaust", 64'(hs_cnt), 64'(2));
        ret_at = cyc + 3;
        repeat (100) step();
        chk("p3_one_more", 64'(hs_cnt), 64'(3));

        // Credit return coinciding with a grant at count 1.
        do_reset();
        mode         = 1;
        flip         = '0;
        req_data[0]  = rand_word();
        req_valid[0] = 1'b1;
        step();
        ret_at = last_grant + 36;
        repeat (115) step();
        chk("p4_grants", 64'(hs_cnt), 64'(3));

        // Reset while waiting on the engine.
        do_reset();
        req_data[1]  = rand_word();
        req_valid[1] = 1'b1;
        repeat (12) step();
        do_reset();
        req_data[1] = rand_word();
        req_data[3] = rand_word();
        req_valid   = 4'b1010;
        repeat (40) step();
        chk("p5_first_grant", 64'(gnt_order.size() > 0 ? gnt_order[0] : -1),
            64'(1));
        chk("p5_id", 64'(last_id), 64'(1));

        // Back-to-back requests with a stale done level at issue.
        do_reset();
        mode         = 1;
        flip         = 32'h0000_FFFF;
        req_data[0]  = 32'hFFFF_FFFF;
        req_valid[0] = 1'b1;
        repeat (80) step();
        chk("p6_handshakes", 64'(hs_cnt), 64'(2));
        chk("p6_second", 64'(last_data), 64'(7'h00));

        // Random traffic with returns and spurious credit pulses, then drain.
        do_reset();
        mode     = 2;
        auto_ret = 1;
        rand_ret = 1;
        repeat (2000) step();
        mode = 0;
        repeat (250) step();
        chk("p7_drained", 64'(exp_q.size()), 64'(0));
        chk("p7_idle", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
